// File: rtl/xgmii_encoder_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : xgmii_encoder_if
//  Purpose  : XGMII word input and 64b/66b block output bundle for the
//             transmit-side encoder (master = MAC/sink side, slave = encoder)
//  Revision : 1.0  initial release
// ============================================================================
interface xgmii_encoder_if #(
  parameter int XGMII_DATA_WIDTH = 32,
  parameter int XGMII_DATA_BYTES = XGMII_DATA_WIDTH / 8,
  parameter int PCS_DATA_WIDTH   = 64
) ();
  logic [XGMII_DATA_WIDTH-1:0] in_xgmii_data;
  logic [XGMII_DATA_BYTES-1:0] in_xgmii_ctl;
  logic                        in_xgmii_valid;
  logic                        out_xgmii_ready;
  logic [PCS_DATA_WIDTH-1:0]   out_encoded_data;
  logic [1:0]                  out_encoded_header;
  logic                        out_encoded_valid;
  logic                        in_encoded_ready;
  logic                        out_encode_error;

  // Environment side: drives XGMII words and the block-accept strobe
  modport master (
    output in_xgmii_data, in_xgmii_ctl, in_xgmii_valid, in_encoded_ready,
    input  out_xgmii_ready, out_encoded_data, out_encoded_header,
           out_encoded_valid, out_encode_error
  );

  // Encoder side
  modport slave (
    input  in_xgmii_data, in_xgmii_ctl, in_xgmii_valid, in_encoded_ready,
    output out_xgmii_ready, out_encoded_data, out_encoded_header,
           out_encoded_valid, out_encode_error
  );
endinterface
`default_nettype wire

// File: rtl/xgmii_encoder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : xgmii_encoder
//  Purpose  : 10G PCS transmit 64b/66b encoder. Pairs two 32-bit XGMII words
//             into a 64-bit column, classifies it (data/idle/start/terminate),
//             tracks packet framing and emits a block with a 2-bit sync header.
//  Revision : 1.0  initial release
// ============================================================================
module xgmii_encoder #(
  parameter int XGMII_DATA_WIDTH = 32,
  parameter int XGMII_DATA_BYTES = XGMII_DATA_WIDTH / 8,
  parameter int PCS_DATA_WIDTH   = 64
) (
  input  wire logic       clk,
  input  wire logic       rst,
  xgmii_encoder_if.slave  bus
);

  localparam logic [0:0] c_st_low  = 1'b0;
  localparam logic [0:0] c_st_high = 1'b1;

  localparam logic [7:0] c_idle  = 8'h07;
  localparam logic [7:0] c_start = 8'hFB;
  localparam logic [7:0] c_term  = 8'hFD;

  localparam logic [1:0] c_hdr_data = 2'b01;
  localparam logic [1:0] c_hdr_ctrl = 2'b10;

  // Block type codes for T0..T7, T0 in the low byte
  localparam logic [63:0] c_term_types = {8'hFF, 8'hE1, 8'hD2, 8'hCC,
                                          8'hB4, 8'hAA, 8'h99, 8'h87};
  localparam logic [63:0] c_err_block  = {8'h1E, {8{7'h1E}}};

  logic [0:0]                  r_state;
  logic [XGMII_DATA_WIDTH-1:0] r_lo_data;
  logic [XGMII_DATA_BYTES-1:0] r_lo_ctl;
  logic                        r_in_packet;
  logic [PCS_DATA_WIDTH-1:0]   r_data;
  logic [1:0]                  r_hdr;
  logic                        r_valid;
  logic                        r_err;

  logic                          w_ready;
  logic                          w_accept;
  logic                          w_load;
  logic [PCS_DATA_WIDTH-1:0]     w_col;
  logic [2*XGMII_DATA_BYTES-1:0] w_ctl;
  logic [7:0]                    w_lane_idle;
  logic                          w_is_data;
  logic                          w_is_idle;
  logic                          w_is_s0;
  logic                          w_is_s4;
  logic                          w_is_term;
  logic [PCS_DATA_WIDTH-1:0]     w_term_payload;
  logic [PCS_DATA_WIDTH-1:0]     w_next_data;
  logic [1:0]                    w_next_hdr;
  logic                          w_next_err;
  logic                          w_next_pkt;

  // A pending block only stalls the high word, since that is what overwrites it
  assign w_ready  = (r_state == c_st_low) | ~r_valid | bus.in_encoded_ready;
  assign w_accept = bus.in_xgmii_valid & w_ready;
  assign w_load   = w_accept & (r_state == c_st_high);

  // The column is the held low half plus the word presented this cycle
  assign w_col = {bus.in_xgmii_data, r_lo_data};
  assign w_ctl = {bus.in_xgmii_ctl, r_lo_ctl};

  // Classify the column against the legal block formats
  always_comb begin
    w_lane_idle = '0;
    for (int k = 0; k < 8; k++) begin
      w_lane_idle[k] = (w_col[8*k +: 8] == c_idle);
    end
    w_is_data = (w_ctl == 8'h00);
    w_is_idle = (w_ctl == 8'hFF) && (&w_lane_idle);
    w_is_s0   = (w_ctl == 8'h01) && (w_col[7:0] == c_start);
    w_is_s4   = (w_ctl == 8'h1F) && (&w_lane_idle[3:0]) && (w_col[39:32] == c_start);
    w_is_term      = 1'b0;
    w_term_payload = '0;
    for (int n = 0; n < 8; n++) begin
      // Lanes 0..n are masked in so only lanes above the terminate must be idle
      if ((w_ctl == (8'hFF << n)) && (w_col[8*n +: 8] == c_term) &&
          ((w_lane_idle | (8'hFF >> (7 - n))) == 8'hFF)) begin
        w_is_term      = 1'b1;
        w_term_payload = (w_col << (64 - 8*n)) >> 8;
        w_term_payload[63:56] = c_term_types[8*n +: 8];
      end
    end
  end

  // Select the block to emit and the next framing state
  always_comb begin
    w_next_data = c_err_block;
    w_next_hdr  = c_hdr_ctrl;
    w_next_err  = 1'b1;
    w_next_pkt  = 1'b0;
    if (w_is_data) begin
      if (r_in_packet) begin
        w_next_data = w_col;
        w_next_hdr  = c_hdr_data;
        w_next_err  = 1'b0;
        w_next_pkt  = 1'b1;
      end
    end else if (w_is_idle) begin
      if (!r_in_packet) begin
        w_next_data = {8'h1E, 56'h0};
        w_next_err  = 1'b0;
      end
    end else if (w_is_s0 || w_is_s4) begin
      // A repeated start is flagged but the packet is still considered open
      w_next_pkt = 1'b1;
      if (!r_in_packet) begin
        w_next_data = w_is_s0 ? {8'h78, w_col[63:8]} : {8'h33, 32'h0, w_col[63:40]};
        w_next_err  = 1'b0;
      end
    end else if (w_is_term) begin
      if (r_in_packet) begin
        w_next_data = w_term_payload;
        w_next_err  = 1'b0;
      end
    end
  end

  // Collector: hold the low word, advance on every accepted word
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= c_st_low;
      r_lo_data <= '0;
      r_lo_ctl  <= '0;
    end else if (w_accept) begin
      if (r_state == c_st_low) begin
        r_lo_data <= bus.in_xgmii_data;
        r_lo_ctl  <= bus.in_xgmii_ctl;
        r_state   <= c_st_high;
      end else begin
        r_state   <= c_st_low;
      end
    end
  end

  // Output register and framing flag; block held until downstream accepts it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data      <= '0;
      r_hdr       <= 2'b00;
      r_valid     <= 1'b0;
      r_err       <= 1'b0;
      r_in_packet <= 1'b0;
    end else begin
      r_err <= 1'b0;
      if (w_load) begin
        r_data      <= w_next_data;
        r_hdr       <= w_next_hdr;
        r_valid     <= 1'b1;
        r_err       <= w_next_err;
        r_in_packet <= w_next_pkt;
      end else if (bus.in_encoded_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign bus.out_xgmii_ready    = w_ready;
  assign bus.out_encoded_data   = r_data;
  assign bus.out_encoded_header = r_hdr;
  assign bus.out_encoded_valid  = r_valid;
  assign bus.out_encode_error   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_xgmii_encoder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_xgmii_encoder
//  Purpose  : Self-checking bench for xgmii_encoder against a byte-level
//             reference model of the 64b/66b block rules and framing.
//  Revision : 1.0  initial release
// ============================================================================
module tb_xgmii_encoder;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  xgmii_encoder_if bus ();

  xgmii_encoder dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit model_pkt = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: returns {error, header, payload}; updates framing flag
  function automatic logic [66:0] model(input logic [63:0] col, input logic [7:0] c,
                                        inout bit pkt);
    logic [7:0]  b [8];
    logic [7:0]  tt [8];
    logic [63:0] errblk;
    logic [63:0] p;
    bit          all_idle;
    int          tn;
    bit          ok;
    tt = '{8'h87, 8'h99, 8'hAA, 8'hB4, 8'hCC, 8'hD2, 8'hE1, 8'hFF};
    errblk = {8'h1E, {8{7'h1E}}};
    all_idle = 1'b1;
    for (int i = 0; i < 8; i++) begin
      b[i] = col[8*i +: 8];
      if (b[i] != 8'h07) all_idle = 1'b0;
    end
    tn = -1;
    for (int n = 0; n < 8; n++) begin
      ok = (b[n] == 8'hFD);
      for (int i = 0; i < 8; i++) begin
        if (i < n && c[i]) ok = 1'b0;
        if (i >= n && !c[i]) ok = 1'b0;
        if (i > n && b[i] != 8'h07) ok = 1'b0;
      end
      if (ok) tn = n;
    end
    if (c == 8'h00) begin
      if (pkt) return {1'b0, 2'b01, col};
      return {1'b1, 2'b10, errblk};
    end
    if (c == 8'hFF && all_idle) begin
      if (pkt) begin pkt = 1'b0; return {1'b1, 2'b10, errblk}; end
      return {1'b0, 2'b10, 64'h1E00_0000_0000_0000};
    end
    if (c == 8'h01 && b[0] == 8'hFB) begin
      if (pkt) return {1'b1, 2'b10, errblk};
      pkt = 1'b1;
      return {1'b0, 2'b10, 8'h78, b[7], b[6], b[5], b[4], b[3], b[2], b[1]};
    end
    if (c == 8'h1F && b[0] == 8'h07 && b[1] == 8'h07 && b[2] == 8'h07 &&
        b[3] == 8'h07 && b[4] == 8'hFB) begin
      if (pkt) return {1'b1, 2'b10, errblk};
      pkt = 1'b1;
      return {1'b0, 2'b10, 8'h33, 32'h0, b[7], b[6], b[5]};
    end
    if (tn >= 0) begin
      if (!pkt) return {1'b1, 2'b10, errblk};
      pkt = 1'b0;
      p = '0;
      p[63:56] = tt[tn];
      for (int j = 0; j < tn; j++) p[56 - 8*tn + 8*j +: 8] = b[j];
      return {1'b0, 2'b10, p};
    end
    pkt = 1'b0;
    return {1'b1, 2'b10, errblk};
  endfunction

  // Present one word and wait (bounded) until it is accepted
  task automatic send_word(input logic [31:0] d, input logic [3:0] c);
    int w;
    bus.in_xgmii_data  = d;
    bus.in_xgmii_ctl   = c;
    bus.in_xgmii_valid = 1'b1;
    w = 0;
    while (!bus.out_xgmii_ready && w < 100) begin
      @(posedge clk); #1;
      w++;
    end
    if (w >= 100) chk("accept_timeout", 64'(bus.out_xgmii_ready), 64'd1);
    @(posedge clk); #1;
    bus.in_xgmii_valid = 1'b0;
  endtask

  task automatic check_out(input string tag, input logic [66:0] e);
    chk({tag, "_valid"}, 64'(bus.out_encoded_valid), 64'd1);
    chk({tag, "_hdr"},   64'(bus.out_encoded_header), 64'(e[65:64]));
    chk({tag, "_data"},  bus.out_encoded_data, e[63:0]);
    chk({tag, "_err"},   64'(bus.out_encode_error), 64'(e[66]));
  endtask

  // Send a full column (optional gap between halves) and check its block
  task automatic send_col(input string tag, input logic [63:0] col, input logic [7:0] c,
                          input int gap);
    logic [66:0] e;
    send_word(col[31:0], c[3:0]);
    repeat (gap) begin @(posedge clk); #1; end
    send_word(col[63:32], c[7:4]);
    e = model(col, c, model_pkt);
    check_out(tag, e);
  endtask

  // Build a random column of a given kind
  task automatic gen_col(input int kind, output logic [63:0] col, output logic [7:0] c);
    int n;
    col = {$urandom, $urandom};
    case (kind)
      0: c = 8'h00;
      1: begin col = {8{8'h07}}; c = 8'hFF; end
      2: begin col[7:0] = 8'hFB; c = 8'h01; end
      3: begin col[39:0] = {8'hFB, 32'h07070707}; c = 8'h1F; end
      4: begin
        n = $urandom_range(0, 7);
        col[8*n +: 8] = 8'hFD;
        for (int i = n + 1; i < 8; i++) col[8*i +: 8] = 8'h07;
        c = 8'hFF << n;
      end
      default: c = 8'($urandom);
    endcase
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] col;
    logic [7:0]  c;
    logic [66:0] e;
    logic [63:0] held;

    rst = 1'b1;
    bus.in_xgmii_data  = '0;
    bus.in_xgmii_ctl   = '0;
    bus.in_xgmii_valid = 1'b0;
    bus.in_encoded_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_data",  bus.out_encoded_data, 64'h0);
    chk("rst_hdr",   64'(bus.out_encoded_header), 64'h0);
    chk("rst_valid", 64'(bus.out_encoded_valid), 64'h0);
    chk("rst_err",   64'(bus.out_encode_error), 64'h0);
    chk("rst_ready", 64'(bus.out_xgmii_ready), 64'h1);
    rst = 1'b0;
    @(posedge clk); #1;

    // Idle stream
    send_col("idle0", {8{8'h07}}, 8'hFF, 0);
    send_col("idle1", {8{8'h07}}, 8'hFF, 0);

    // S0, data, T3
    send_col("s0",   64'h0706_0504_0302_01FB, 8'h01, 0);
    send_col("dat",  64'h1122_3344_5566_7788, 8'h00, 1);
    send_col("t3",   64'h0707_0707_FDA3_B2C1, 8'hF8, 0);

    // S4, T7
    send_col("s4",   64'hEEDD_CCFB_0707_0707, 8'h1F, 0);
    send_col("t7",   64'hFD66_5544_3322_1100, 8'h80, 2);

    // Data outside a packet: error block, single-cycle pulse
    send_col("orph", 64'hDEAD_BEEF_0BAD_F00D, 8'h00, 0);
    @(posedge clk); #1;
    chk("orph_pulse_end", 64'(bus.out_encode_error), 64'h0);

    // Backpressure
    bus.in_encoded_ready = 1'b0;
    send_col("bp_a", {8{8'h07}}, 8'hFF, 0);
    held = bus.out_encoded_data;
    col  = 64'h7766_5544_3322_11FB;
    send_word(col[31:0], 4'h1);
    chk("bp_ready_low", 64'(bus.out_xgmii_ready), 64'h0);
    bus.in_xgmii_data  = col[63:32];
    bus.in_xgmii_ctl   = 4'h0;
    bus.in_xgmii_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("bp_hold_data",  bus.out_encoded_data, held);
      chk("bp_hold_valid", 64'(bus.out_encoded_valid), 64'h1);
      chk("bp_hold_ready", 64'(bus.out_xgmii_ready), 64'h0);
    end
    bus.in_encoded_ready = 1'b1;
    #1;
    chk("bp_release_ready", 64'(bus.out_xgmii_ready), 64'h1);
    @(posedge clk); #1;
    bus.in_xgmii_valid = 1'b0;
    e = model(col, 8'h01, model_pkt);
    check_out("bp_b", e);
    send_col("t0",   64'h0707_0707_0707_07FD, 8'hFF, 0);

    // Reset between the halves of a column
    send_col("s0b",  64'hA1A2_A3A4_A5A6_A7FB, 8'h01, 0);
    send_word(32'h1234_5678, 4'h0);
    rst = 1'b1;
    #2;
    chk("mrst_data",  bus.out_encoded_data, 64'h0);
    chk("mrst_hdr",   64'(bus.out_encoded_header), 64'h0);
    chk("mrst_valid", 64'(bus.out_encoded_valid), 64'h0);
    chk("mrst_err",   64'(bus.out_encode_error), 64'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    model_pkt = 1'b0;
    send_col("fresh", 64'h0102_0304_0506_0708, 8'h00, 0);
    send_col("fresh_s0", 64'h0102_0304_0506_07FB, 8'h01, 0);

    // Randomized columns with random gaps
    for (int i = 0; i < 60; i++) begin
      gen_col(int'($urandom_range(0, 5)), col, c);
      send_col("rnd", col, c, int'($urandom_range(0, 2)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
